// File: rtl/pid_controller_pkg.sv
// Shared widths, pipeline depth and types for the PID servo core.
package pid_controller_pkg;

  localparam int DEF_W_DATA  = 18;
  localparam int DEF_W_COEF  = 16;
  localparam int DEF_W_COMP  = 64;
  localparam int W_DAC       = 16;
  localparam int PIPE_STAGES = 4;

  typedef logic signed [DEF_W_DATA-1:0] sample_t;
  typedef logic signed [DEF_W_COEF-1:0] coef_t;
  typedef logic signed [DEF_W_COMP-1:0] acc_t;

  typedef enum logic [1:0] {
    CLAMP_NONE = 2'd0,
    CLAMP_LO   = 2'd1,
    CLAMP_HI   = 2'd2
  } clamp_e;

  typedef struct packed {
    logic [W_DAC-1:0] dac_min;
    logic [W_DAC-1:0] dac_max;
    logic [W_DAC-1:0] dac_init;
  } dac_cfg_t;

endpackage

// File: rtl/pid_controller_core_opp_clamp.sv
// Output stage: offset the PID result by the init code, clamp to [min, max], truncate to 16 bits.
// With PID_ANTI_WINDUP_EN defined, the registered clamp direction is exported.
module opp_clamp
  import pid_controller_pkg::*;
#(
  parameter int W_COMP       = DEF_W_COMP,
  parameter int DAC_OUT_INIT = 32768
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     flush,
  input  logic signed [W_COMP-1:0] pid_data,
  input  logic                     pid_valid,
  input  dac_cfg_t                 cfg,
  input  logic [W_DAC-1:0]         idle_code,
  output logic [W_DAC-1:0]         dac_data,
  output logic                     dac_valid
`ifdef PID_ANTI_WINDUP_EN
  ,
  output clamp_e                   clamp_state
`endif
);

  logic signed [W_COMP-1:0] init_ext, lo_ext, hi_ext, sum;
  clamp_e                   sel;
  logic [W_DAC-1:0]         code;

  assign init_ext = {{(W_COMP-W_DAC){1'b0}}, cfg.dac_init};
  assign lo_ext   = {{(W_COMP-W_DAC){1'b0}}, cfg.dac_min};
  assign hi_ext   = {{(W_COMP-W_DAC){1'b0}}, cfg.dac_max};
  assign sum      = init_ext + pid_data;

  // An inverted window (min > max) pins the output to min.
  always_comb begin
    // NOTE: every variable assigned in combinational logic gets a default first, so no path infers a latch.
    sel = CLAMP_NONE;
    if (cfg.dac_min > cfg.dac_max || sum < lo_ext) sel = CLAMP_LO;
    else if (sum > hi_ext)                        sel = CLAMP_HI;
  end

  always_comb begin
    code = sum[W_DAC-1:0];
    case (sel)
      CLAMP_LO: code = cfg.dac_min;
      CLAMP_HI: code = cfg.dac_max;
      default:  code = sum[W_DAC-1:0];
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_in) begin
      dac_data  <= W_DAC'(DAC_OUT_INIT);
      dac_valid <= 1'b0;
    end else if (flush) begin
      dac_data  <= idle_code;
      dac_valid <= 1'b0;
    end else begin
      dac_valid <= pid_valid;
      if (pid_valid) dac_data <= code;
    end
  end

`ifdef PID_ANTI_WINDUP_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)         clamp_state <= CLAMP_NONE;
    else if (flush)     clamp_state <= CLAMP_NONE;
    else if (pid_valid) clamp_state <= sel;
  end
`endif

endmodule

// File: rtl/pid_controller_core.sv
// Single-channel PID servo: error, integral/derivative, PID sum, then offset+clamp to a DAC code.
// Optional PID_ANTI_WINDUP_EN holds the integral while the output sits in a limit it is pushing into.
module pid_controller_core
  import pid_controller_pkg::*;
#(
  parameter int W_DATA        = DEF_W_DATA,
  parameter int W_COEF        = DEF_W_COEF,
  parameter int W_COMP        = DEF_W_COMP,
  parameter int PID_SETP_INIT = 0,
  parameter int PID_PCF_INIT  = 0,
  parameter int PID_ICF_INIT  = 0,
  parameter int PID_DCF_INIT  = 0,
  parameter int DAC_MAX_INIT  = 65535,
  parameter int DAC_MIN_INIT  = 0,
  parameter int DAC_OUT_INIT  = 32768
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic signed [W_DATA-1:0] data_in,
  input  logic                     data_valid_in,
  input  logic                     lock_en_in,
  input  logic                     update_in,
  input  logic signed [W_COEF-1:0] cfg_setpoint_in,
  input  logic signed [W_COEF-1:0] cfg_p_coef_in,
  input  logic signed [W_COEF-1:0] cfg_i_coef_in,
  input  logic signed [W_COEF-1:0] cfg_d_coef_in,
  input  logic [W_DAC-1:0]         cfg_dac_min_in,
  input  logic [W_DAC-1:0]         cfg_dac_max_in,
  input  logic [W_DAC-1:0]         cfg_dac_init_in,
  output logic signed [W_COMP-1:0] pid_data_out,
  output logic                     pid_data_valid_out,
  output logic [W_DAC-1:0]         dac_data_out,
  output logic                     dac_data_valid_out
);

  logic signed [W_COEF-1:0] setp_q, p_q, i_q, d_q;
  dac_cfg_t                 dac_cfg_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      setp_q    <= W_COEF'(PID_SETP_INIT);
      p_q       <= W_COEF'(PID_PCF_INIT);
      i_q       <= W_COEF'(PID_ICF_INIT);
      d_q       <= W_COEF'(PID_DCF_INIT);
      dac_cfg_q <= '{dac_min: W_DAC'(DAC_MIN_INIT), dac_max: W_DAC'(DAC_MAX_INIT),
                     dac_init: W_DAC'(DAC_OUT_INIT)};
    end else if (update_in) begin
      setp_q    <= cfg_setpoint_in;
      p_q       <= cfg_p_coef_in;
      i_q       <= cfg_i_coef_in;
      d_q       <= cfg_d_coef_in;
      dac_cfg_q <= '{dac_min: cfg_dac_min_in, dac_max: cfg_dac_max_in, dac_init: cfg_dac_init_in};
    end
  end

  logic                     accept, flush, s1_valid, s2_valid, windup_hold;
  logic signed [W_COMP-1:0] s1_err, s2_err, s2_int, s2_deriv;
  logic signed [W_COMP-1:0] integral, error_prev, int_next, pid_next;
  logic signed [W_COEF-1:0] s1_p, s1_i, s1_d, s2_p, s2_i, s2_d;
  dac_cfg_t                 s1_dac, s2_dac, s3_dac;

  assign accept   = data_valid_in & lock_en_in;
  assign flush    = ~lock_en_in;
  assign int_next = windup_hold ? integral : integral + s1_err;
  assign pid_next = W_COMP'(s2_p) * s2_err + W_COMP'(s2_i) * s2_int + W_COMP'(s2_d) * s2_deriv;

  // Stage-2 feedback into integral/error_prev lets back-to-back samples chain every cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid           <= 1'b0;
      s2_valid           <= 1'b0;
      pid_data_valid_out <= 1'b0;
      pid_data_out       <= '0;
      integral           <= '0;
      error_prev         <= '0;
    end else if (flush) begin
      s1_valid           <= 1'b0;
      s2_valid           <= 1'b0;
      pid_data_valid_out <= 1'b0;
      integral           <= '0;
      error_prev         <= '0;
    end else begin
      s1_valid           <= accept;
      s2_valid           <= s1_valid;
      pid_data_valid_out <= s2_valid;
      if (s1_valid) begin
        integral   <= int_next;
        error_prev <= s1_err;
      end
      if (s2_valid) pid_data_out <= pid_next;
    end
  end

  // NOTE: datapath registers carry no reset; they are only consumed behind a reset valid bit.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      s1_err <= W_COMP'(setp_q) - W_COMP'(data_in);
      s1_p   <= p_q;
      s1_i   <= i_q;
      s1_d   <= d_q;
      s1_dac <= dac_cfg_q;
    end
    if (s1_valid) begin
      s2_err   <= s1_err;
      s2_int   <= int_next;
      s2_deriv <= s1_err - error_prev;
      s2_p     <= s1_p;
      s2_i     <= s1_i;
      s2_d     <= s1_d;
      s2_dac   <= s1_dac;
    end
    if (s2_valid) s3_dac <= s2_dac;
  end

`ifdef PID_ANTI_WINDUP_EN
  clamp_e clamp_state;
  assign windup_hold = (clamp_state == CLAMP_HI && !s1_err[W_COMP-1] && s1_err != '0) ||
                       (clamp_state == CLAMP_LO &&  s1_err[W_COMP-1]);
`else
  assign windup_hold = 1'b0;
`endif

  opp_clamp #(
    .W_COMP       (W_COMP),
    .DAC_OUT_INIT (DAC_OUT_INIT)
  ) u_opp_clamp (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .flush       (flush),
    .pid_data    (pid_data_out),
    .pid_valid   (pid_data_valid_out),
    .cfg         (s3_dac),
    .idle_code   (dac_cfg_q.dac_init),
    .dac_data    (dac_data_out),
    .dac_valid   (dac_data_valid_out)
`ifdef PID_ANTI_WINDUP_EN
    ,
    .clamp_state (clamp_state)
`endif
  );

endmodule

// File: tb/tb_pid_controller_core.sv
// Scoreboard bench for pid_controller_core: a reference model queues expected results at drive time.
module tb_pid_controller_core;
  import pid_controller_pkg::*;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic signed [17:0] data_in;
  logic               data_valid_in, lock_en_in, update_in;
  logic signed [15:0] cfg_setpoint_in, cfg_p_coef_in, cfg_i_coef_in, cfg_d_coef_in;
  logic [15:0]        cfg_dac_min_in, cfg_dac_max_in, cfg_dac_init_in;
  logic signed [63:0] pid_data_out;
  logic               pid_data_valid_out, dac_data_valid_out;
  logic [15:0]        dac_data_out;

  pid_controller_core dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .data_in            (data_in),
    .data_valid_in      (data_valid_in),
    .lock_en_in         (lock_en_in),
    .update_in          (update_in),
    .cfg_setpoint_in    (cfg_setpoint_in),
    .cfg_p_coef_in      (cfg_p_coef_in),
    .cfg_i_coef_in      (cfg_i_coef_in),
    .cfg_d_coef_in      (cfg_d_coef_in),
    .cfg_dac_min_in     (cfg_dac_min_in),
    .cfg_dac_max_in     (cfg_dac_max_in),
    .cfg_dac_init_in    (cfg_dac_init_in),
    .pid_data_out       (pid_data_out),
    .pid_data_valid_out (pid_data_valid_out),
    .dac_data_out       (dac_data_out),
    .dac_data_valid_out (dac_data_valid_out)
  );

  always #5 clk_in = ~clk_in;

  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;
  bit     lock  = 1'b1;
  longint m_int, m_prev;
  longint cur_setp, cur_p, cur_i, cur_d, cur_min, cur_max, cur_init;
  longint exp_pid[$], obs_pid[$], got_pid[$];
  int     exp_dac[$], obs_dac[$], got_dac[$];
  int     obs_pcyc[$], got_cyc[$];

  always @(negedge clk_in) begin
    if (pid_data_valid_out) begin
      obs_pid.push_back(pid_data_out);
      obs_pcyc.push_back(cyc);
    end
    if (dac_data_valid_out) obs_dac.push_back(int'(dac_data_out));
    cyc++;
  end

  function automatic void model_reset();
    m_int = 0; m_prev = 0;
    cur_setp = 0; cur_p = 0; cur_i = 0; cur_d = 0;
    cur_min = 0; cur_max = 65535; cur_init = 32768;
  endfunction

  function automatic void model_sample(longint d);
    longint e, deriv, pid, sum, dac;
    e      = cur_setp - d;
    m_int  = m_int + e;
    deriv  = e - m_prev;
    m_prev = e;
    pid    = cur_p * e + cur_i * m_int + cur_d * deriv;
    sum    = cur_init + pid;
    if (cur_min > cur_max)   dac = cur_min;
    else if (sum > cur_max)  dac = cur_max;
    else if (sum < cur_min)  dac = cur_min;
    else                     dac = sum;
    exp_pid.push_back(pid);
    exp_dac.push_back(int'(dac));
  endfunction

  task automatic cycle(input bit v, input int d, input bit upd);
    @(negedge clk_in);
    data_valid_in = v;
    data_in       = 18'(d);
    lock_en_in    = lock;
    update_in     = upd;
    if (!lock) begin
      m_int = 0; m_prev = 0;
    end else if (v) begin
      model_sample(longint'(d));
    end
    if (upd) begin
      cur_setp = longint'(cfg_setpoint_in);
      cur_p    = longint'(cfg_p_coef_in);
      cur_i    = longint'(cfg_i_coef_in);
      cur_d    = longint'(cfg_d_coef_in);
      cur_min  = longint'(cfg_dac_min_in);
      cur_max  = longint'(cfg_dac_max_in);
      cur_init = longint'(cfg_dac_init_in);
    end
  endtask

  task automatic clear_state();
    lock = 1'b0;
    cycle(0, 0, 0);
    lock = 1'b1;
  endtask

  // Waits (bounded) for every queued result, then compares in order.
  task automatic drain();
    int     n = 0;
    longint p, pe;
    int     q, qe;
    while ((obs_pid.size() < exp_pid.size() || obs_dac.size() < exp_dac.size()) &&
           n < PIPE_STAGES + 30) begin
      cycle(0, 0, 0);
      n++;
    end
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    total++;
    if (obs_pid.size() != exp_pid.size() || obs_dac.size() != exp_dac.size()) begin
      bad++;
      $display("FAIL pulse_count: pid got=%0d want=%0d, dac got=%0d want=%0d",
               obs_pid.size(), exp_pid.size(), obs_dac.size(), exp_dac.size());
    end
    got_pid.delete(); got_dac.delete(); got_cyc.delete();
    while (exp_pid.size() > 0 && obs_pid.size() > 0) begin
      p  = obs_pid.pop_front();
      pe = exp_pid.pop_front();
      got_pid.push_back(p);
      got_cyc.push_back(obs_pcyc.pop_front());
      total++;
      if (p !== pe) begin
        bad++;
        $display("FAIL pid_value: got=%0d want=%0d", p, pe);
      end
    end
    while (exp_dac.size() > 0 && obs_dac.size() > 0) begin
      q  = obs_dac.pop_front();
      qe = exp_dac.pop_front();
      got_dac.push_back(q);
      total++;
      if (q !== qe) begin
        bad++;
        $display("FAIL dac_value: got=%0d want=%0d", q, qe);
      end
    end
    exp_pid.delete(); obs_pid.delete(); obs_pcyc.delete();
    exp_dac.delete(); obs_dac.delete();
  endtask

  task automatic expect_val(input string name, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1; data_valid_in = 1'b0; data_in = '0; lock_en_in = 1'b1; update_in = 1'b0;
    cfg_setpoint_in = '0; cfg_p_coef_in = '0; cfg_i_coef_in = '0; cfg_d_coef_in = '0;
    cfg_dac_min_in = '0; cfg_dac_max_in = 16'hFFFF; cfg_dac_init_in = 16'd32768;
    model_reset();
    #12;
    expect_val("reset_pid", pid_data_out, 0);
    expect_val("reset_pid_valid", longint'(pid_data_valid_out), 0);
    expect_val("reset_dac", longint'(dac_data_out), 32768);
    expect_val("reset_dac_valid", longint'(dac_data_valid_out), 0);
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic test_common();
    cfg_setpoint_in = 16'sd0; cfg_p_coef_in = 16'sd10; cfg_i_coef_in = 16'sd3; cfg_d_coef_in = 16'sd2;
    cfg_dac_init_in = 16'd39321; cfg_dac_min_in = 16'd13107; cfg_dac_max_in = 16'd52428;
    cycle(0, 0, 1);
    for (int k = 0; k < 20; k++) cycle(1, 655, 0);
    drain();
    if (got_pid.size() < 20 || got_dac.size() < 20) begin
      total++; bad++;
      $display("FAIL common_count: got=%0d want=20", got_pid.size());
    end else begin
      expect_val("common_pid1", got_pid[0], -9825);
      expect_val("common_pid2", got_pid[1], -10480);
      expect_val("common_pid3", got_pid[2], -12445);
      expect_val("common_dac1", longint'(got_dac[0]), 29496);
      expect_val("common_dac2", longint'(got_dac[1]), 28841);
      expect_val("clamp_dac_hold", longint'(got_dac[18]), 13107);
      expect_val("clamp_dac_last", longint'(got_dac[19]), 13107);
      expect_val("clamp_pid_falling", longint'(got_pid[19] < got_pid[18]), 1);
    end
  endtask

  task automatic test_lock();
    lock = 1'b0;
    repeat (5) cycle(1, 655, 0);
    cycle(0, 0, 0);
    expect_val("lock_off_dac", longint'(dac_data_out), 39321);
    expect_val("lock_off_pulses", longint'(obs_pid.size() + obs_dac.size()), 0);
    lock = 1'b1;
    cycle(1, 655, 0);
    drain();
    if (got_pid.size() < 1) begin
      total++; bad++;
      $display("FAIL relock_count: got=0 want=1");
    end else begin
      expect_val("relock_pid", got_pid[0], -9825);
    end
  endtask

  task automatic test_update();
    clear_state();
    cfg_p_coef_in = 16'sd0;
    cycle(1, 655, 1);
    cycle(1, 655, 0);
    drain();
    if (got_pid.size() < 2) begin
      total++; bad++;
      $display("FAIL update_count: got=%0d want=2", got_pid.size());
    end else begin
      expect_val("update_old_cfg", got_pid[0], -9825);
      expect_val("update_new_cfg", got_pid[1], -3930);
    end
    cfg_p_coef_in = 16'sd10;
    cycle(0, 0, 1);
  endtask

  task automatic test_back_to_back();
    clear_state();
    repeat (4) cycle(1, 655, 0);
    drain();
    if (got_pid.size() < 4) begin
      total++; bad++;
      $display("FAIL b2b_count: got=%0d want=4", got_pid.size());
    end else begin
      expect_val("b2b_pid1", got_pid[0], -9825);
      expect_val("b2b_pid2", got_pid[1], -10480);
      expect_val("b2b_pid3", got_pid[2], -12445);
      expect_val("b2b_pid4", got_pid[3], -14410);
      expect_val("b2b_spacing", longint'(got_cyc[3] - got_cyc[0]), 3);
    end
  endtask

  task automatic test_reset_midpipe();
    cycle(1, 655, 0);
    cycle(0, 0, 0);
    #2 rst_in = 1'b1;
    #1;
    expect_val("midrst_pid", pid_data_out, 0);
    expect_val("midrst_dac", longint'(dac_data_out), 32768);
    expect_val("midrst_valids", longint'(pid_data_valid_out | dac_data_valid_out), 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    exp_pid.delete(); exp_dac.delete();
    model_reset();
    drain();
  endtask

  initial begin
    test_reset();
    test_common();
    test_lock();
    test_update();
    test_back_to_back();
    test_reset_midpipe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
